// File: rtl/chunked_serial_subtractor.sv
// rtl/chunked_serial_subtractor.sv - multi-cycle chunked subtractor (diff = a - b - bin), optional ovf via SUBTRACTOR_OVERFLOW_EN
module chunked_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Control state
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Working operands shift right one chunk per cycle, so the active chunk is always the low bits
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;

  // Working difference fills from the top as chunks arrive LSB-first
  logic [WIDTH-1:0] wdiff_q, wdiff_d;

  // Published results; only move on the publish edge
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             msb_borrow_in;
`endif

  // Chunk datapath signals
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] d_chunk;
  logic             borrow_next;
  logic [WIDTH-1:0] d_ext;
  logic [WIDTH-1:0] wdiff_next;

  // One chunk of subtraction with borrow, and the working diff after inserting it at the top
  always_comb begin
    a_chunk = a_q[CHUNK-1:0];
    b_chunk = b_q[CHUNK-1:0];
    {borrow_next, d_chunk} = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
    d_ext = '0;
    d_ext[CHUNK-1:0] = d_chunk;
    wdiff_next = (wdiff_q >> CHUNK) | (d_ext << (WIDTH - CHUNK));
`ifdef SUBTRACTOR_OVERFLOW_EN
    // Borrow into the top bit is recoverable from the sum bit: d = a ^ b ^ borrow_in
    msb_borrow_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ d_chunk[CHUNK-1];
`endif
  end

  // Next-state logic: capture in IDLE, one chunk per cycle in RUN, publish on the last chunk
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    wdiff_d  = wdiff_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          wdiff_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        borrow_d = borrow_next;
        wdiff_d  = wdiff_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          diff_d  = wdiff_next;
          bout_d  = borrow_next;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef SUBTRACTOR_OVERFLOW_EN
          ovf_d   = msb_borrow_in ^ borrow_next;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      wdiff_q  <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      wdiff_q  <= wdiff_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SUBTRACTOR_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUBTRACTOR_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_subtractor.sv
// tb/tb_chunked_serial_subtractor.sv - directed and random checks of chunked_serial_subtractor
module tb_chunked_serial_subtractor;

  localparam int W  = 8;
  localparam int NI = 4;  // instances with CHUNK = 1, 2, 4, 8
  localparam int M  = 1;  // CHUNK=2 instance used for directed tests

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy_w [NI];
  logic         done_w [NI];
  logic         bout_w [NI];
  logic [W-1:0] diff_w [NI];
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic         ovf_w  [NI];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chunked_serial_subtractor #(.WIDTH(W), .CHUNK(1 << g)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy_w[g]),
      .done (done_w[g]),
      .diff (diff_w[g]),
      .bout (bout_w[g])
`ifdef SUBTRACTOR_OVERFLOW_EN
      ,
      .ovf  (ovf_w[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single op on the CHUNK=2 instance; inj >= 0 raises start (a=1,b=1) at that RUN sample
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input int inj, input logic [W-1:0] prev,
                        output logic [W-1:0] rd, output logic rb, output int nbusy, output int ndone);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    nbusy = 0; ndone = 0; rd = '0; rb = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy_w[M]) begin
        nbusy++;
        check_eq("hold_while_busy", 32'(diff_w[M]), 32'(prev));
      end
      if (done_w[M]) begin
        ndone++;
        rd = diff_w[M];
        rb = bout_w[M];
      end
      if (i == inj) begin
        a = 8'd1; b = 8'd1; bin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    int           nb, nd;
    logic         found;
    int           gap;
    logic [W-1:0] ra, rbv;
    logic         rbin;
    logic [W:0]   full;
    int           sr;
    logic         seen [NI];
    logic [W-1:0] gd   [NI];
    logic         gb   [NI];
`ifdef SUBTRACTOR_OVERFLOW_EN
    logic         go   [NI];
`endif

    // Reset held with random activity on inputs
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_diff", 32'(diff_w[M]), 32'd0);
      check_eq("rst_bout", 32'(bout_w[M]), 32'd0);
      check_eq("rst_busy", 32'(busy_w[M]), 32'd0);
      check_eq("rst_done", 32'(done_w[M]), 32'd0);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;

    // Basic
    run_op(8'd200, 8'd55, 1'b0, -1, 8'd0, rd, rb, nb, nd);
    check_eq("basic_diff", 32'(rd), 32'd145);
    check_eq("basic_bout", 32'(rb), 32'd0);
    check_eq("basic_busy_cycles", 32'(nb), 32'd4);
    check_eq("basic_done_pulses", 32'(nd), 32'd1);
    check_eq("basic_held", 32'(diff_w[M]), 32'd145);

    // Borrow cases
    run_op(8'd10, 8'd20, 1'b1, -1, 8'd145, rd, rb, nb, nd);
    check_eq("borrow_diff", 32'(rd), 32'd245);
    check_eq("borrow_bout", 32'(rb), 32'd1);
    run_op(8'd0, 8'd0, 1'b1, -1, 8'd245, rd, rb, nb, nd);
    check_eq("zero_bin_diff", 32'(rd), 32'd255);
    check_eq("zero_bin_bout", 32'(rb), 32'd1);
    check_eq("zero_bin_held_bout", 32'(bout_w[M]), 32'd1);

    // Start while busy is ignored
    run_op(8'd100, 8'd1, 1'b0, 1, 8'd255, rd, rb, nb, nd);
    check_eq("busy_start_diff", 32'(rd), 32'd99);
    check_eq("busy_start_bout", 32'(rb), 32'd0);
    check_eq("busy_start_done_pulses", 32'(nd), 32'd1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_diff", 32'(diff_w[M]), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of an operation
    run_op(8'd7, 8'd2, 1'b0, -1, 8'd0, rd, rb, nb, nd);
    check_eq("pre_abort_diff", 32'(rd), 32'd5);
    @(negedge clk);
    a = 8'd50; b = 8'd5; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("abort_busy_before", 32'(busy_w[M]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy_w[M]), 32'd0);
    check_eq("abort_diff", 32'(diff_w[M]), 32'd0);
    check_eq("abort_bout", 32'(bout_w[M]), 32'd0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_w[M]) nd++;
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_w[M]) nd++;
    end
    check_eq("abort_no_done", 32'(nd), 32'd0);
    run_op(8'd50, 8'd5, 1'b0, -1, 8'd0, rd, rb, nb, nd);
    check_eq("after_abort_diff", 32'(rd), 32'd45);

    // Back-to-back with start held during the done cycle
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_w[M]) found = 1'b1;
    end
    check_eq("b2b_first_done_seen", 32'(found), 32'd1);
    check_eq("b2b_first_diff", 32'(diff_w[M]), 32'h7F);
    check_eq("b2b_first_bout", 32'(bout_w[M]), 32'd0);
`ifdef SUBTRACTOR_OVERFLOW_EN
    check_eq("b2b_first_ovf", 32'(ovf_w[M]), 32'd1);
`endif
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    found = 1'b0;
    gap = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_w[M]) begin
        found = 1'b1;
        gap = k;
      end
    end
    check_eq("b2b_second_done_seen", 32'(found), 32'd1);
    check_eq("b2b_gap", 32'(gap), 32'd5);
    check_eq("b2b_second_diff", 32'(diff_w[M]), 32'h02);
    check_eq("b2b_second_bout", 32'(bout_w[M]), 32'd0);
`ifdef SUBTRACTOR_OVERFLOW_EN
    check_eq("b2b_second_ovf", 32'(ovf_w[M]), 32'd0);
`endif

    // Let every instance go idle, then random vectors on all chunk sizes
    for (int i = 0; i < 12; i++) @(negedge clk);
    for (int v = 0; v < 50; v++) begin
      ra = W'($urandom); rbv = W'($urandom); rbin = 1'($urandom);
      a = ra; b = rbv; bin = rbin; start = 1'b1;
      for (int g = 0; g < NI; g++) seen[g] = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
        for (int g = 0; g < NI; g++) begin
          if (done_w[g]) begin
            seen[g] = 1'b1;
            gd[g] = diff_w[g];
            gb[g] = bout_w[g];
`ifdef SUBTRACTOR_OVERFLOW_EN
            go[g] = ovf_w[g];
`endif
          end
        end
        @(negedge clk);
      end
      full = {1'b0, ra} - {1'b0, rbv} - {{W{1'b0}}, rbin};
      sr = int'($signed(ra)) - int'($signed(rbv)) - int'(rbin);
      for (int g = 0; g < NI; g++) begin
        check_eq($sformatf("rand%0d_c%0d_done", v, 1 << g), 32'(seen[g]), 32'd1);
        if (seen[g]) begin
          check_eq($sformatf("rand%0d_c%0d_diff", v, 1 << g), 32'(gd[g]), 32'(full[W-1:0]));
          check_eq($sformatf("rand%0d_c%0d_bout", v, 1 << g), 32'(gb[g]), 32'(full[W]));
`ifdef SUBTRACTOR_OVERFLOW_EN
          check_eq($sformatf("rand%0d_c%0d_ovf", v, 1 << g), 32'(go[g]),
                   32'((sr < -128 || sr > 127) ? 1 : 0));
`endif
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
